// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared load-type codes, FSM states and legality check
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Unknown funct3 codes and accesses that straddle their natural alignment are refused.
  function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/half out of a word and extends it
module load_align
  import load_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  assign w_byte_sh = i_rdata >> {i_off, 3'b000};
  assign w_half_sh = i_rdata >> {i_off[1], 4'b0000};

  // Select lane and apply sign or zero extension by load type.
  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      F3_LBU:  o_data = {24'h0, w_byte_sh[7:0]};
      F3_LH:   o_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      F3_LHU:  o_data = {16'h0, w_half_sh[15:0]};
      F3_LW:   o_data = i_rdata;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - one-transaction data-memory load stage with write-back and stall
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              delayed_load,
  input  logic [ADDR_W-1:0] delayed_addr,
  input  logic [4:0]        delayed_rd,
  input  logic [2:0]        delayed_funct3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              load_busy,
  output logic              load_fault
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic              r_wb_en;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_fault;
  logic              w_illegal;
  logic              w_accept;
  logic              w_resp;
  logic [DATA_W-1:0] w_align;

  assign w_illegal = is_illegal(delayed_funct3, delayed_addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && delayed_load;
  assign w_resp    = (r_state == ST_WAIT) && mem_rvalid;

  load_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_rdata  (mem_rdata),
    .o_data   (w_align)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: a legal load issues, the request waits for ready, then for data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (delayed_load && !w_illegal) w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_ready)                  w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rvalid)                 w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs: request while in REQ, stall whenever not idle.
  always_comb begin
    mem_req   = 1'b0;
    load_busy = 1'b0;
    case (r_state)
      ST_REQ:  begin mem_req = 1'b1; load_busy = 1'b1; end
      ST_WAIT: load_busy = 1'b1;
      default: ;
    endcase
  end

  // Capture the load only from IDLE; register write-back and fault pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      r_fault <= 1'b0;
      if (w_accept) begin
        r_addr   <= delayed_addr;
        r_rd     <= delayed_rd;
        r_funct3 <= delayed_funct3;
        r_fault  <= w_illegal;
      end
      if (w_resp) begin
        r_wb_en   <= (r_rd != 5'd0);
        r_wb_rd   <= r_rd;
        r_wb_data <= w_align;
      end
    end
  end

  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign wb_en      = r_wb_en;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign load_fault = r_fault;

endmodule

// File: doc/load_unit.md
# load_unit

Memory-access stage directly downstream of the one-cycle load delay register. Takes the delayed load flag, effective address and destination register from that register, runs one data-memory read transaction over a request/response handshake, and aligns and sign- or zero-extends the returned word. It then issues a single-cycle register-file write-back. While a load is in flight it holds a stall signal so the front of the pipeline freezes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; RV32I loads only)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- delayed_load  in  1  load request from the delay stage, one-cycle pulse per load
- delayed_addr  in  ADDR_W  effective byte address
- delayed_rd  in  5  destination register
- delayed_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read word
- wb_en  out  1  register-file write strobe, one-cycle pulse
- wb_rd  out  5  write-back register
- wb_data  out  DATA_W  aligned, extended load result
- load_busy  out  1  stall request to the pipeline
- load_fault  out  1  one-cycle pulse: misaligned access or illegal funct3

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - On delayed_load=1, capture addr, rd and funct3.
  - If the access is illegal, pulse load_fault next cycle and stay in IDLE. Illegal means any of:
    - funct3 is 011, 110 or 111;
    - LH/LHU with addr[0]=1;
    - LW with addr[1:0]≠00.
  - Otherwise go to REQ.
- **REQ**
  - mem_req=1, mem_addr driven from the captured address.
  - mem_ready=1 → WAIT.
  - mem_ready=0 → stay in REQ; mem_addr held stable.
- **WAIT**
  - mem_req=0.
  - mem_rvalid=1 → register the write-back outputs and return to IDLE.
- Extraction, with byte offset off=addr[1:0]:
  - LB/LBU: byte mem_rdata[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half mem_rdata[16*off[1]+15:16*off[1]], sign- or zero-extended.
  - LW: the full word.
- rd=0: the transaction runs normally, but wb_en stays 0. wb_data is still updated.
- load_busy = (state≠IDLE), combinational from the state register.
- delayed_load while busy is a protocol violation (the pipeline is stalled). It is ignored and the captured fields are unchanged.
- mem_rvalid in IDLE or REQ is ignored. mem_ready outside REQ is ignored.

## Timing
- Reset (asynchronous, rst=0):
  - state=IDLE;
  - mem_req, wb_en and load_fault = 0;
  - mem_addr, wb_rd and wb_data = 0;
  - all captured fields = 0.
- Reset mid-transaction: the outstanding transaction is abandoned, no write-back occurs, and a late mem_rvalid after reset is ignored.
- Best-case load latency:
  - delayed_load sampled at edge N;
  - mem_req high in cycle N+1 (mem_ready=1);
  - WAIT in cycle N+2 (mem_rvalid=1);
  - wb_en high for exactly cycle N+3.
- Each cycle of mem_ready=0 or mem_rvalid=0 adds one cycle of latency.
- load_busy is high from cycle N+1 through the cycle in which the response is accepted. It is low in the wb_en cycle, so a new delayed_load may be sampled at the same edge on which wb_en rises.
- load_fault is high for cycle N+1 only. load_busy stays 0 for a faulting load.
- wb_rd and wb_data hold their values after wb_en drops, until the next write-back.

## Structure
- Shared package `load_pkg`:
  - funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - state enum: ST_IDLE, ST_REQ, ST_WAIT.
- Sub-module `load_align`: purely combinational. Inputs are (funct3, off, rdata); output is the extended data. It is instantiated once inside load_unit.

## Test plan
- LW addr=0x100, mem_ready and mem_rvalid at first opportunity, rdata=0xDEADBEEF, rd=5 → wb_en in cycle N+3 with rd=5, data=0xDEADBEEF; mem_addr=0x100; load_busy high for 2 cycles.
- LB addr=0x203, rdata=0x80_12_34_56 → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr=0x202 → 0x00008012.
- LH addr=0x301 → load_fault pulse at N+1; no mem_req, no wb_en, load_busy=0. Repeat with funct3=011 at addr=0x300 → same response.
- LW with mem_ready delayed 3 cycles and mem_rvalid delayed 2 cycles → mem_addr stable throughout REQ; wb_en at N+8; load_busy high for 7 cycles.
- LW with rd=0 → full handshake occurs, wb_en stays 0.
- rst asserted while in WAIT, then mem_rvalid=1 after release → all outputs 0, no wb_en. A following LW completes normally.
